// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide control unit: state encoding,
// opcode values, iteration count and small two's-complement helpers.
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MULT = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int ITERATIONS = 32;
    localparam int CNT_W      = $clog2(ITERATIONS);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

    // Magnitude of a signed word; 0x80000000 maps to itself, which is
    // the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/response bundle between the main control FSM (master) and the
// multiply/divide unit (slave).
interface muldiv_ctrl_if;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        divby0;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, divby0, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, divby0, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// Purely combinational datapath: one radix-2 Booth step and one restoring
// division step. All state lives in muldiv_ctrl.
module muldiv_step (
    input  logic [32:0] acc_i,
    input  logic [31:0] mplr_i,
    input  logic        prev_i,
    input  logic [31:0] mcand_i,
    output logic [32:0] acc_o,
    output logic [31:0] mplr_o,
    output logic        prev_o,
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] dvs_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] mcand_ext;
    logic [32:0] sum;
    logic [32:0] shifted;
    logic [32:0] trial;

    // The accumulator is one bit wider than the operands so that
    // subtracting 0x80000000 cannot overflow.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        mcand_ext = {mcand_i[31], mcand_i};
        sum       = acc_i;
        unique case ({mplr_i[0], prev_i})
            2'b01:   sum = acc_i + mcand_ext;
            2'b10:   sum = acc_i - mcand_ext;
            default: sum = acc_i;
        endcase
        acc_o  = {sum[32], sum[32:1]};
        mplr_o = {sum[0], mplr_i[31:1]};
        prev_o = mplr_i[0];
    end

    // Bit 32 of the trial difference is set exactly when the divisor does not fit.
    always_comb begin
        shifted = {rem_i, quo_i[31]};
        trial   = shifted - {1'b0, dvs_i};
        if (!trial[32]) begin
            rem_o = trial[31:0];
            quo_o = {quo_i[30:0], 1'b1};
        end else begin
            rem_o = shifted[31:0];
            quo_o = {quo_i[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative signed multiply (Booth, 32 cycles) and divide (restoring, 32
// cycles plus sign fix-up) unit driving the HI/LO registers.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input logic         clk,
    input logic         rst_n,
    muldiv_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [32:0]       acc_q, acc_d;
    logic [31:0]       mplr_q, mplr_d;
    logic              prev_q, prev_d;
    logic [31:0]       mcand_q, mcand_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              dz_q, dz_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;

    logic [32:0]       booth_acc;
    logic [31:0]       booth_mplr;
    logic              booth_prev;
    logic [31:0]       div_rem;
    logic [31:0]       div_quo;

    // Division reuses the Booth registers: acc holds the remainder, mplr the
    // shifting dividend/quotient and mcand the divisor magnitude.
    muldiv_step u_step (
        .acc_i   (acc_q),
        .mplr_i  (mplr_q),
        .prev_i  (prev_q),
        .mcand_i (mcand_q),
        .acc_o   (booth_acc),
        .mplr_o  (booth_mplr),
        .prev_o  (booth_prev),
        .rem_i   (acc_q[31:0]),
        .quo_i   (mplr_q),
        .dvs_i   (mcand_q),
        .rem_o   (div_rem),
        .quo_o   (div_quo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mplr_d    = mplr_q;
        prev_d    = prev_q;
        mcand_d   = mcand_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cnt_d  = '0;
                    acc_d  = '0;
                    prev_d = 1'b0;
                    dz_d   = 1'b0;
                    unique case (bus.op)
                        OP_MULT: begin
                            mplr_d  = bus.b;
                            mcand_d = bus.a;
                            state_d = S_MULT;
                        end
                        OP_DIV: begin
                            if (bus.b == '0) begin
                                dz_d    = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                mplr_d    = mag32(bus.a);
                                mcand_d   = mag32(bus.b);
                                neg_quo_d = bus.a[31] ^ bus.b[31];
                                neg_rem_d = bus.a[31];
                                state_d   = S_DIV;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_MULT: begin
                acc_d  = booth_acc;
                mplr_d = booth_mplr;
                prev_d = booth_prev;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    hi_d    = booth_acc[31:0];
                    lo_d    = booth_mplr;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                acc_d  = {1'b0, div_rem};
                mplr_d = div_quo;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                lo_d    = neg_if(neg_quo_q, mplr_q);
                hi_d    = neg_if(neg_rem_q, acc_q[31:0]);
                state_d = S_DONE;
            end
            S_DONE: begin
                dz_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mplr_q    <= '0;
            prev_q    <= 1'b0;
            mcand_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mplr_q    <= mplr_d;
            prev_q    <= prev_d;
            mcand_q   <= mcand_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy   = (state_q == S_MULT) || (state_q == S_DIV) || (state_q == S_FIX);
    assign bus.done   = (state_q == S_DONE);
    assign bus.divby0 = (state_q == S_DONE) && dz_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;

endmodule
